// File: rtl/to_upper.sv
// Streaming ASCII case converter: one registered stage with valid/ready
// flow control, selectable case mode and a saturating count of changed bytes.
module to_upper #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic [CNT_W-1:0] conv_count,
    input  logic             clr_count
);

    typedef enum logic [1:0] {
        MODE_UPPER  = 2'b00,
        MODE_LOWER  = 2'b01,
        MODE_PASS   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_char_q, out_char_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       accept;
    logic       is_lower;
    logic       is_upper;
    logic [7:0] conv_char;
    logic       changed;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign is_lower = (in_char >= 8'd97) && (in_char <= 8'd122);
    assign is_upper = (in_char >= 8'd65) && (in_char <= 8'd90);

    // Case flips only ever touch bit 5, so bytes >= 128 keep bit 7 intact.
    always_comb begin
        conv_char = in_char;
        case (mode_e'(mode))
            MODE_UPPER:  if (is_lower) conv_char = in_char - 8'd32;
            MODE_LOWER:  if (is_upper) conv_char = in_char + 8'd32;
            MODE_PASS:   conv_char = in_char;
            MODE_TOGGLE: begin
                if (is_lower)      conv_char = in_char - 8'd32;
                else if (is_upper) conv_char = in_char + 8'd32;
            end
            default:     conv_char = in_char;
        endcase
    end

    assign changed = (conv_char != in_char);

    always_comb begin
        out_valid_d = out_valid_q;
        out_char_d  = out_char_q;
        count_d     = count_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_char_d  = conv_char;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear takes priority over a same-cycle increment.
        if (clr_count) begin
            count_d = '0;
        end else if (accept && changed && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            count_q     <= count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_char   = out_char_q;
    assign conv_count = count_q;

endmodule

// File: tb/tb_to_upper.sv
// Directed bench for to_upper: a 16-bit counter instance and a 4-bit one
// (for saturation) driven by the same stimulus.
module tb_to_upper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic [15:0] conv_count;
    logic        clr_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [7:0]  out_char4;
    logic [3:0]  conv_count4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    to_upper #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
        .conv_count (conv_count),
        .clr_count  (clr_count)
    );

    to_upper #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready4),
        .in_char    (in_char),
        .mode       (mode),
        .out_valid  (out_valid4),
        .out_ready  (out_ready),
        .out_char   (out_char4),
        .conv_count (conv_count4),
        .clr_count  (clr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) begin
            $display("[TB] ok   %s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            fails++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One character through an idle pipe with out_ready=1.
    task automatic send_one(input string tag, input logic [7:0] c, input logic [1:0] m,
                            input logic [7:0] exp);
        in_char  = c;
        mode     = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_char"}, {24'd0, out_char}, {24'd0, exp});
    endtask

    logic [7:0] s_in  [19];
    logic [7:0] s_exp [19];

    initial begin
        s_in  = '{40,72,183,131,124,20,235,97,65,122,71,109,146,48,207,58,123,148,127};
        s_exp = '{40,72,183,131,124,20,235,65,65,90,71,77,146,48,207,58,123,148,127};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        mode      = 2'b00;
        out_ready = 1'b1;
        clr_count = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_char", {24'd0, out_char}, 32'd0);
        check("rst_conv_count", {16'd0, conv_count}, 32'd0);
        check("rst_conv_count4", {28'd0, conv_count4}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #10 rst_n = 1'b1;   // released at t=12, between edges

        // Full-rate stream, mode 00
        @(posedge clk); #1;
        for (int i = 0; i < 19; i++) begin
            in_char  = s_in[i];
            mode     = 2'b00;
            in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("stream%0d", i), {23'd0, out_valid, out_char}, {23'd0, 1'b1, s_exp[i]});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream_drained", {31'd0, out_valid}, 32'd0);
        check("stream_hold_char", {24'd0, out_char}, 32'd127);
        check("stream_count", {16'd0, conv_count}, 32'd3);

        // Boundaries, mode 00 (adds 2 to count)
        send_one("b96",  8'd96,  2'b00, 8'd96);
        send_one("b97",  8'd97,  2'b00, 8'd65);
        send_one("b122", 8'd122, 2'b00, 8'd90);
        send_one("b123", 8'd123, 2'b00, 8'd123);
        send_one("b64",  8'd64,  2'b00, 8'd64);
        send_one("b91",  8'd91,  2'b00, 8'd91);
        check("bound_count", {16'd0, conv_count}, 32'd5);

        // Modes (01: +1, 10: +0, 11: +2)
        send_one("m01_a", 8'd97, 2'b01, 8'd97);
        send_one("m01_Q", 8'd81, 2'b01, 8'd113);
        send_one("m10_a", 8'd97, 2'b10, 8'd97);
        send_one("m10_Q", 8'd81, 2'b10, 8'd81);
        send_one("m11_a", 8'd97, 2'b11, 8'd65);
        send_one("m11_Q", 8'd81, 2'b11, 8'd113);
        send_one("m11_hi", 8'd225, 2'b11, 8'd225);
        check("mode_count", {16'd0, conv_count}, 32'd8);
        @(posedge clk); #1;

        // Backpressure
        mode      = 2'b00;
        out_ready = 1'b0;
        in_char   = 8'd104;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_char = 8'd105;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_hold_char%0d", k), {24'd0, out_char}, 32'd72);
            check($sformatf("bp_hold_valid%0d", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_in_ready%0d", k), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check("bp_count_held", {16'd0, conv_count}, 32'd9);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_up", {31'd0, in_ready}, 32'd1);
        check("bp_first_out", {23'd0, out_valid, out_char}, {23'd0, 1'b1, 8'd72});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_out", {23'd0, out_valid, out_char}, {23'd0, 1'b1, 8'd73});
        @(posedge clk); #1;
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);
        check("bp_count", {16'd0, conv_count}, 32'd10);

        // Asynchronous reset while a character is held
        out_ready = 1'b0;
        in_char   = 8'd100;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", {31'd0, out_valid}, 32'd0);
        check("ar_out_char", {24'd0, out_char}, 32'd0);
        check("ar_conv_count", {16'd0, conv_count}, 32'd0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("ar_idle_after", {31'd0, out_valid}, 32'd0);
        send_one("ar_x", 8'd120, 2'b00, 8'd88);
        check("ar_count", {16'd0, conv_count}, 32'd1);

        // Clear wins over simultaneous increment
        in_char   = 8'd98;
        mode      = 2'b00;
        in_valid  = 1'b1;
        clr_count = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        clr_count = 1'b0;
        check("clr_char", {24'd0, out_char}, 32'd66);
        check("clr_count", {16'd0, conv_count}, 32'd0);
        check("clr_count4", {28'd0, conv_count4}, 32'd0);

        // Saturation on the 4-bit instance
        for (int k = 0; k < 16; k++) begin
            in_char  = 8'd97 + 8'(k);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("sat_count4", {28'd0, conv_count4}, 32'd15);
        check("sat_count16", {16'd0, conv_count}, 32'd16);
        send_one("sat_more", 8'd122, 2'b00, 8'd90);
        check("sat_count4_hold", {28'd0, conv_count4}, 32'd15);
        check("sat_char4", {24'd0, out_char4}, 32'd90);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
